bayer_remosaic: RTL and testbench

Converts a 24-bit-per-pixel RGB video stream (parallel R/G/B lanes, G_PIXELS pixels per beat) back into a single-plane Bayer CFA stream in one of four mosaic orders. It is the inverse of the Bayer interpolation core. It sits in front of that core to synthesise sensor-like input from RGB sources, for loopback of the demosaic path and for generating test frames in hardware. Stream framing is the same as the interpolation core's: DATA_VALID_I marks active pixels, and EOF_I is pulsed after the last line of a frame.

---
 rtl/bayer_remosaic.sv | 118 +++++++++++
 tb/tb_bayer_remosaic.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bayer_remosaic.sv
// RGB-to-Bayer remosaic: picks one colour component per pixel according to row/column
// parity and a per-frame mosaic order, with a two-stage register pipeline.
module bayer_remosaic #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_PIXELS     = 1
) (
  input  logic                             RESETN_I,
  input  logic                             SYS_CLK_I,
  input  logic                             DATA_VALID_I,
  input  logic                             EOF_I,
  input  logic [G_PIXELS*G_DATA_WIDTH-1:0] R_I,
  input  logic [G_PIXELS*G_DATA_WIDTH-1:0] G_I,
  input  logic [G_PIXELS*G_DATA_WIDTH-1:0] B_I,
  input  logic [1:0]                       BAYER_FORMAT,
  output logic                             BAYER_VALID_O,
  output logic [G_PIXELS*G_DATA_WIDTH-1:0] DATA_O,
  output logic                             EOF_O
);

  localparam int   DW       = G_PIXELS * G_DATA_WIDTH;
  localparam logic ODD_BEAT = logic'((G_PIXELS % 2) == 1);

  logic          row_par, col_par, frame_open, vld_d;
  logic [1:0]    fmt_q;
  logic          line_end;
  logic [1:0]    fmt_cur;

  logic          s1_vld, s1_eof, s1_row, s1_col;
  logic [1:0]    s1_fmt;
  logic [DW-1:0] s1_r, s1_g, s1_b;
  logic [DW-1:0] data_nxt;

  assign line_end = vld_d & ~DATA_VALID_I;
  // The opening beat of a frame must already use the format it is about to latch.
  assign fmt_cur  = frame_open ? fmt_q : BAYER_FORMAT;

  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      row_par    <= 1'b0;
      col_par    <= 1'b0;
      frame_open <= 1'b0;
      vld_d      <= 1'b0;
      fmt_q      <= 2'd0;
    end else begin
      vld_d <= DATA_VALID_I;
      if (DATA_VALID_I) begin
        if (!frame_open) begin
          fmt_q      <= BAYER_FORMAT;
          frame_open <= 1'b1;
        end
        if (ODD_BEAT) col_par <= ~col_par;
      end
      if (line_end) begin
        row_par <= ~row_par;
        col_par <= 1'b0;
      end
      // Written last so end-of-frame wins over a coincident line end.
      if (EOF_I) begin
        row_par    <= 1'b0;
        col_par    <= 1'b0;
        frame_open <= 1'b0;
      end
    end
  end

  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      s1_vld <= 1'b0;
      s1_eof <= 1'b0;
      s1_row <= 1'b0;
      s1_col <= 1'b0;
      s1_fmt <= 2'd0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld <= DATA_VALID_I;
      s1_eof <= EOF_I;
      s1_row <= row_par;
      s1_col <= col_par;
      s1_fmt <= fmt_cur;
      s1_r   <= R_I;
      s1_g   <= G_I;
      s1_b   <= B_I;
    end
  end

  for (genvar i = 0; i < G_PIXELS; i++) begin : g_lane
    localparam logic LANE_ODD = logic'((i % 2) == 1);
    logic                    rr, cc;
    logic [G_DATA_WIDTH-1:0] sel;

    // Every order is RGGB with the row and/or column parity flipped.
    assign rr = s1_row ^ s1_fmt[1];
    assign cc = s1_col ^ LANE_ODD ^ s1_fmt[0];

    always_comb begin
      sel = s1_g[i*G_DATA_WIDTH +: G_DATA_WIDTH];
      if (!rr && !cc)     sel = s1_r[i*G_DATA_WIDTH +: G_DATA_WIDTH];
      else if (rr && cc)  sel = s1_b[i*G_DATA_WIDTH +: G_DATA_WIDTH];
    end

    assign data_nxt[i*G_DATA_WIDTH +: G_DATA_WIDTH] = sel;
  end

  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      BAYER_VALID_O <= 1'b0;
      EOF_O         <= 1'b0;
      DATA_O        <= '0;
    end else begin
      BAYER_VALID_O <= s1_vld;
      EOF_O         <= s1_eof;
      if (s1_vld) DATA_O <= data_nxt;
    end
  end

endmodule

// File: tb/tb_bayer_remosaic.sv
// Bench for bayer_remosaic: one- and two-pixel-per-beat instances share framing; expected
// samples come from a per-format table and are queued with their due cycle.
module tb_bayer_remosaic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        eof = 1'b0;
  logic [1:0]  fmt = 2'd0;
  logic [7:0]  r1 = 8'h11, g1 = 8'h22, b1 = 8'h33;
  logic [15:0] r2 = 16'hA1A0, g2 = 16'hB1B0, b2 = 16'hC1C0;
  logic        v1, e1, v2, e2;
  logic [7:0]  d1;
  logic [15:0] d2;

  always #5 clk = ~clk;

  bayer_remosaic #(.G_DATA_WIDTH(8), .G_PIXELS(1)) dut1 (
    .RESETN_I(rst_n), .SYS_CLK_I(clk), .DATA_VALID_I(vld), .EOF_I(eof),
    .R_I(r1), .G_I(g1), .B_I(b1), .BAYER_FORMAT(fmt),
    .BAYER_VALID_O(v1), .DATA_O(d1), .EOF_O(e1));

  bayer_remosaic #(.G_DATA_WIDTH(8), .G_PIXELS(2)) dut2 (
    .RESETN_I(rst_n), .SYS_CLK_I(clk), .DATA_VALID_I(vld), .EOF_I(eof),
    .R_I(r2), .G_I(g2), .B_I(b2), .BAYER_FORMAT(fmt),
    .BAYER_VALID_O(v2), .DATA_O(d2), .EOF_O(e2));

  typedef struct {
    logic [1:0]  fmt;
    logic [7:0]  e00, e01, e10, e11;
    logic [15:0] e2r0, e2r1;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  vec_t tbl[4];
  exp_t q1[$];
  exp_t q2[$];
  int   qe[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp1(input int fe, input int row, input int col);
    case ({row[0], col[0]})
      2'b00:   return tbl[fe].e00;
      2'b01:   return tbl[fe].e01;
      2'b10:   return tbl[fe].e10;
      default: return tbl[fe].e11;
    endcase
  endfunction

  task automatic check_out();
    logic ev1, ev2, eve;
    ev1 = (q1.size() > 0) && (q1[0].due == cyc);
    ev2 = (q2.size() > 0) && (q2[0].due == cyc);
    eve = (qe.size() > 0) && (qe[0] == cyc);
    cmp("valid_p1", {15'd0, v1}, {15'd0, ev1});
    if (v1 && ev1) cmp("data_p1", {8'd0, d1}, q1[0].data);
    if (ev1) void'(q1.pop_front());
    cmp("valid_p2", {15'd0, v2}, {15'd0, ev2});
    if (v2 && ev2) cmp("data_p2", d2, q2[0].data);
    if (ev2) void'(q2.pop_front());
    cmp("eof_p1", {15'd0, e1}, {15'd0, eve});
    cmp("eof_p2", {15'd0, e2}, {15'd0, eve});
    if (eve) void'(qe.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_out();
  endtask

  task automatic beat(input int fe, input int row, input int col, input logic [1:0] fd);
    exp_t e;
    vld = 1'b1;
    eof = 1'b0;
    fmt = fd;
    e.due  = cyc + 2;
    e.data = {8'd0, exp1(fe, row, col)};
    q1.push_back(e);
    e.data = row[0] ? tbl[fe].e2r1 : tbl[fe].e2r0;
    q2.push_back(e);
    tick();
  endtask

  task automatic idle(input int n, input int eof_at);
    for (int k = 0; k < n; k++) begin
      vld = 1'b0;
      eof = (k == eof_at);
      if (k == eof_at) qe.push_back(cyc + 2);
      tick();
    end
    eof = 1'b0;
  endtask

  // 4-beat line; the driven format switches from fd_a to fd_b at beat sw.
  task automatic line(input int fe, input int row, input logic [1:0] fd_a,
                      input logic [1:0] fd_b, input int sw);
    for (int b = 0; b < 4; b++) beat(fe, row, b % 2, (b < sw) ? fd_a : fd_b);
  endtask

  task automatic frame(input logic [1:0] fd, input int fe, input int nlines, input int eof_at);
    for (int l = 0; l < nlines; l++) begin
      line(fe, l % 2, fd, fd, 4);
      idle(4, (l == nlines - 1) ? eof_at : -1);
    end
  endtask

  initial begin
    tbl[0] = '{2'd0, 8'h11, 8'h22, 8'h22, 8'h33, 16'hB1A0, 16'hC1B0};
    tbl[1] = '{2'd1, 8'h22, 8'h11, 8'h33, 8'h22, 16'hA1B0, 16'hB1C0};
    tbl[2] = '{2'd2, 8'h22, 8'h33, 8'h11, 8'h22, 16'hC1B0, 16'hB1A0};
    tbl[3] = '{2'd3, 8'h33, 8'h22, 8'h22, 8'h11, 16'hB1C0, 16'hA1B0};

    repeat (2) @(negedge clk);
    cmp("rst_valid", {15'd0, v1}, 16'd0);
    cmp("rst_data", d2, 16'd0);
    cmp("rst_eof", {15'd0, e2}, 16'd0);
    rst_n = 1'b1;
    idle(2, -1);

    // All four mosaic orders, one frame each; the first beat must use the new order.
    for (int i = 0; i < 4; i++) frame(tbl[i].fmt, i, 2, 1);

    // Format change in the middle of line 1 must not affect the current frame.
    line(0, 0, 2'd0, 2'd0, 4);
    idle(4, -1);
    line(0, 1, 2'd0, 2'd3, 2);
    idle(4, 1);
    frame(2'd3, 3, 2, 1);

    // EOF on the falling edge of valid after a row-0 line: the next frame starts at row 0.
    frame(2'd0, 0, 3, 0);
    frame(2'd0, 0, 2, 0);

    // Asynchronous reset in the middle of a line discards in-flight beats.
    beat(0, 0, 0, 2'd0);
    beat(0, 0, 1, 2'd0);
    beat(0, 0, 0, 2'd0);
    rst_n = 1'b0;
    vld   = 1'b0;
    #1;
    cmp("midrst_valid_p1", {15'd0, v1}, 16'd0);
    cmp("midrst_data_p1", {8'd0, d1}, 16'd0);
    cmp("midrst_valid_p2", {15'd0, v2}, 16'd0);
    cmp("midrst_data_p2", d2, 16'd0);
    q1.delete();
    q2.delete();
    qe.delete();
    tick();
    rst_n = 1'b1;
    idle(4, -1);
    frame(2'd0, 0, 2, 1);

    idle(6, -1);
    cmp("drain_q1", 16'(q1.size()), 16'd0);
    cmp("drain_q2", 16'(q2.size()), 16'd0);
    cmp("drain_eof", 16'(qe.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
